spi_master_engine: RTL and testbench
====================================

Name: spi_master_engine

Overview:
Synthesizable SPI master that drives one SPI bus (sclk, cs_n, mosi) and samples miso. It also contains a passive pin monitor that reassembles each completed frame. The block sits between a testbench/host command port and the SPI slave pins.
- Driver half: runs a full-duplex word transfer when commanded.
- Monitor half: observes only the pins (not driver internals) and reports each frame's mosi/miso words.

Parameters:
DATA_WIDTH  8  bits per frame
DIV_WIDTH  8  width of the baud_div input
MSB_FIRST  1  1 = shift MSB first, 0 = LSB first

Ports:
pclk  in  1  system clock, all logic on rising edge
areset  in  1  reset; synchronous, active-high
start  in  1  one-cycle request to begin a frame (accepted only when busy=0)
tx_data  in  DATA_WIDTH  word to shift out on mosi
cpol  in  1  clock polarity, latched at start
cpha  in  1  clock phase, latched at start
baud_div  in  DIV_WIDTH  sclk half-period in pclk cycles; 0 treated as 1
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of frame
rx_data  out  DATA_WIDTH  word received on miso, valid when done=1, held until next done
sclk  out  1  SPI clock
cs_n  out  1  active-low slave select
mosi  out  1  master out
miso  in  1  master in
mon_valid  out  1  one-cycle pulse, monitor frame complete
mon_mosi  out  DATA_WIDTH  monitored mosi word
mon_miso  out  DATA_WIDTH  monitored miso word

Behaviour:
- Reset (areset=1 at a pclk edge), applied next edge including mid-frame:
  - cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0.
  - mon_valid=0, mon_mosi=0, mon_miso=0.
  - Partial frames are discarded; no done and no mon_valid for them.
- Let N = max(baud_div,1), latched at start.
- Driver FSM states: IDLE, LEAD, XFER, TRAIL.
- IDLE:
  - sclk follows the cpol input; cs_n=1.
  - start=1 latches cpol, cpha, N and tx_data; busy=1; next state LEAD.
- LEAD: cs_n=0, lasts N cycles.
  - CPHA=0: first data bit is on mosi for the whole of LEAD.
- XFER: 2*DATA_WIDTH sclk edges, one every N cycles. Leading edge = cpol to !cpol.
  - CPHA=0: sample miso on leading edges; shift next mosi bit on trailing edges (no shift after the last edge).
  - CPHA=1: drive mosi bit on leading edges; sample miso on trailing edges.
  - Bit order follows MSB_FIRST.
- TRAIL: sclk = cpol, cs_n=0, lasts N cycles. Then:
  - cs_n=1, done=1 for one cycle, rx_data updated, busy=0, return to IDLE.
- cs_n low duration per frame = (2*DATA_WIDTH+2)*N pclk cycles.
- start while busy=1 is ignored. start in the same cycle as done is ignored; a start the cycle after done is accepted.
- Monitor (independent of driver state):
  - Registers sclk, cs_n, mosi, miso each pclk cycle and detects sclk edges relative to the cpol value captured when cs_n falls.
  - Samples both mosi and miso on the same edge type the mode uses for sampling; mode comes from the latched cpha of the driver.
  - On cs_n rising after exactly DATA_WIDTH samples: load mon_mosi/mon_miso and pulse mon_valid 1 cycle, within 2 pclk cycles of cs_n rising.
  - On cs_n rising with a sample count other than DATA_WIDTH: discard, no mon_valid.
- Latency from start to cs_n falling: 1 pclk cycle.

Test Plan:
- Mode 0 (cpol=0,cpha=0), baud_div=2, tx_data=0xA5, slave returns 0x3C MSB-first -> cs_n low 36 cycles; mosi shows 1,0,1,0,0,1,0,1; rx_data=0x3C at done; mon_mosi=0xA5, mon_miso=0x3C, mon_valid one pulse.
- Mode 3 (cpol=1,cpha=1), baud_div=1, tx_data=0x0F, slave 0xF0 -> sclk idles 1; cs_n low 18 cycles; rx_data=0xF0; mon words 0x0F/0xF0.
- baud_div=0 -> behaves as baud_div=1 (18-cycle frame).
- start pulsed again while busy -> ignored; exactly one done and one mon_valid.
- areset asserted midway through a mode-1 frame -> next edge cs_n=1, sclk=0, busy=0; no done, no mon_valid; a following start with tx_data=0x81 completes normally with mon_mosi=0x81.
- MSB_FIRST=0, tx_data=0x01 -> first mosi bit is 1, rx assembled LSB-first.

Source files
------------

// File: rtl/spi_master_engine.sv
// -----------------------------------------------------------------------------
// spi_master_engine
//
// Single-bus SPI master with a passive pin monitor.
//
// The driver half runs one full-duplex frame of DATA_WIDTH bits per accepted
// start request. cpol, cpha, the half-period N = max(baud_div,1) and tx_data
// are all latched when start is accepted. A frame consists of:
//   - LEAD:  N cycles with cs_n low.
//   - XFER:  2*DATA_WIDTH sclk toggles, one every N cycles.
//   - TRAIL: N cycles with cs_n low.
// cs_n is therefore low for (2*DATA_WIDTH+2)*N cycles.
//
// The monitor half watches only the bus pins. It reassembles the mosi and miso
// words from the pins and reports each complete frame.
//
// Ports:
//   pclk       in   system clock, rising edge
//   areset     in   synchronous active-high reset
//   start      in   one-cycle frame request, honoured only while idle
//   tx_data    in   word to shift out
//   cpol/cpha  in   SPI mode, latched at start
//   baud_div   in   sclk half-period in pclk cycles (0 acts as 1)
//   busy       out  frame in progress
//   done       out  one-cycle end-of-frame pulse
//   rx_data    out  received word, updated with done
//   sclk/cs_n/mosi out, miso in   SPI pins
//   mon_valid  out  one-cycle pulse when the monitor saw a complete frame
//   mon_mosi   out  monitored mosi word
//   mon_miso   out  monitored miso word
// -----------------------------------------------------------------------------
module spi_master_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  mon_valid,
    output logic [DATA_WIDTH-1:0] mon_mosi,
    output logic [DATA_WIDTH-1:0] mon_miso
);

    localparam int EC_W = $clog2(2 * DATA_WIDTH + 1);
    localparam int SC_W = $clog2(DATA_WIDTH + 1) + 1;
    localparam logic [EC_W-1:0] EDGES     = EC_W'(2 * DATA_WIDTH);
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_WIDTH - 1);
    localparam logic [SC_W-1:0] SAMPLES   = SC_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } state_t;

    // Bit that goes on the wire first for the configured bit order.
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    // Discard the bit just sent, moving the next one into the send position.
    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    // Append a received bit so that after DATA_WIDTH bits the word is aligned.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                       input logic b);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
    endfunction

    // ---------------------------------------------------------------- driver
    state_t                  state_r, state_nx;
    logic [DIV_WIDTH-1:0]    div_cnt_r;
    logic [DIV_WIDTH-1:0]    n_r;
    logic [EC_W-1:0]         edge_cnt_r;
    logic                    cpol_r, cpha_r;
    logic [DATA_WIDTH-1:0]   tx_sh_r, rx_sh_r, rx_data_r;
    logic                    sclk_r, cs_n_r, mosi_r, busy_r, done_r;

    logic accept_s, toggle_s, finish_s;
    logic phase_end_s, leading_s, last_edge_s, sample_s, drive_s;

    assign phase_end_s = (state_r != ST_IDLE) && (div_cnt_r == (n_r - DIV_WIDTH'(1)));
    // edge_cnt_r counts toggles already made, so the upcoming toggle is leading
    // (odd-numbered) when the count is even.
    assign leading_s   = ~edge_cnt_r[0];
    assign last_edge_s = (edge_cnt_r == LAST_EDGE);
    // Sample on leading edges in CPHA=0, on trailing edges in CPHA=1.
    assign sample_s    = toggle_s & (leading_s ^ cpha_r);
    // CPHA=0 shifts on trailing edges except the final one; CPHA=1 drives on leading edges.
    assign drive_s     = toggle_s & (cpha_r ? leading_s : (~leading_s & ~last_edge_s));

    // State register.
    always_ff @(posedge pclk) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nx = state_r;
        accept_s = 1'b0;
        toggle_s = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (start && !done_r) begin
                    state_nx = ST_LEAD;
                    accept_s = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LEAD: begin
                if (phase_end_s) begin
                    state_nx = ST_XFER;
                    toggle_s = 1'b1;
                end else begin
                    state_nx = ST_LEAD;
                end
            end
            ST_XFER: begin
                // Each half-period starts with a toggle; once all toggles have
                // been made, the final half-period ends by entering TRAIL.
                if (phase_end_s) begin
                    if (edge_cnt_r == EDGES) begin
                        state_nx = ST_TRAIL;
                    end else begin
                        toggle_s = 1'b1;
                    end
                end else begin
                    state_nx = ST_XFER;
                end
            end
            ST_TRAIL: begin
                if (phase_end_s) begin
                    state_nx = ST_IDLE;
                    finish_s = 1'b1;
                end else begin
                    state_nx = ST_TRAIL;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Half-period divider and sclk toggle counter.
    always_ff @(posedge pclk) begin
        if (areset) begin
            div_cnt_r  <= '0;
            edge_cnt_r <= '0;
        end else begin
            if (accept_s || phase_end_s || (state_r == ST_IDLE)) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
            end
            if (accept_s) begin
                edge_cnt_r <= '0;
            end else if (toggle_s) begin
                edge_cnt_r <= edge_cnt_r + EC_W'(1);
            end
        end
    end

    // Frame configuration latched on accept.
    always_ff @(posedge pclk) begin
        if (areset) begin
            cpol_r <= 1'b0;
            cpha_r <= 1'b0;
            n_r    <= DIV_WIDTH'(1);
        end else if (accept_s) begin
            cpol_r <= cpol;
            cpha_r <= cpha;
            n_r    <= (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
        end
    end

    // Pin drivers, shift registers and host-side status.
    always_ff @(posedge pclk) begin
        if (areset) begin
            sclk_r    <= 1'b0;
            cs_n_r    <= 1'b1;
            mosi_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rx_data_r <= '0;
            tx_sh_r   <= '0;
            rx_sh_r   <= '0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                busy_r  <= 1'b1;
                cs_n_r  <= 1'b0;
                sclk_r  <= cpol;
                rx_sh_r <= '0;
                if (cpha) begin
                    mosi_r  <= 1'b0;
                    tx_sh_r <= tx_data;
                end else begin
                    // CPHA=0 presents the first bit for the whole lead-in.
                    mosi_r  <= first_bit(tx_data);
                    tx_sh_r <= shift_out(tx_data);
                end
            end else if (finish_s) begin
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                cs_n_r    <= 1'b1;
                mosi_r    <= 1'b0;
                sclk_r    <= cpol_r;
                rx_data_r <= rx_sh_r;
            end else if (state_r == ST_IDLE) begin
                // Idle sclk tracks the requested polarity.
                sclk_r <= cpol;
            end else begin
                if (toggle_s) begin
                    sclk_r <= ~sclk_r;
                end
                if (sample_s) begin
                    rx_sh_r <= shift_in(rx_sh_r, miso);
                end
                if (drive_s) begin
                    mosi_r  <= first_bit(tx_sh_r);
                    tx_sh_r <= shift_out(tx_sh_r);
                end
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;
    assign sclk    = sclk_r;
    assign cs_n    = cs_n_r;
    assign mosi    = mosi_r;

    // --------------------------------------------------------------- monitor
    logic                  sclk_q_r, sclk_q2_r, cs_n_q_r, cs_n_q2_r, mosi_q_r, miso_q_r;
    logic                  mon_cpol_r;
    logic [SC_W-1:0]       mon_cnt_r;
    logic [DATA_WIDTH-1:0] mon_mosi_sh_r, mon_miso_sh_r, mon_mosi_r, mon_miso_r;
    logic                  mon_valid_r;
    logic                  mon_fall_s, mon_rise_s, mon_edge_s, mon_lead_s, mon_sample_s;

    assign mon_fall_s   = cs_n_q2_r & ~cs_n_q_r;
    assign mon_rise_s   = ~cs_n_q2_r & cs_n_q_r;
    assign mon_edge_s   = ~cs_n_q_r & ~cs_n_q2_r & (sclk_q_r != sclk_q2_r);
    // Leading edge leaves the idle level captured when cs_n fell.
    assign mon_lead_s   = (sclk_q2_r == mon_cpol_r);
    assign mon_sample_s = mon_edge_s & (mon_lead_s ^ cpha_r);

    // Pin synchroniser stage plus one delayed copy for edge detection.
    always_ff @(posedge pclk) begin
        if (areset) begin
            sclk_q_r  <= 1'b0;
            sclk_q2_r <= 1'b0;
            cs_n_q_r  <= 1'b1;
            cs_n_q2_r <= 1'b1;
            mosi_q_r  <= 1'b0;
            miso_q_r  <= 1'b0;
        end else begin
            sclk_q_r  <= sclk_r;
            sclk_q2_r <= sclk_q_r;
            cs_n_q_r  <= cs_n_r;
            cs_n_q2_r <= cs_n_q_r;
            mosi_q_r  <= mosi_r;
            miso_q_r  <= miso;
        end
    end

    // Frame reassembly from the observed pins.
    always_ff @(posedge pclk) begin
        if (areset) begin
            mon_cpol_r    <= 1'b0;
            mon_cnt_r     <= '0;
            mon_mosi_sh_r <= '0;
            mon_miso_sh_r <= '0;
            mon_mosi_r    <= '0;
            mon_miso_r    <= '0;
            mon_valid_r   <= 1'b0;
        end else begin
            mon_valid_r <= 1'b0;
            if (mon_fall_s) begin
                mon_cpol_r    <= sclk_q_r;
                mon_cnt_r     <= '0;
                mon_mosi_sh_r <= '0;
                mon_miso_sh_r <= '0;
            end else if (mon_rise_s) begin
                // Short or overlong frames are dropped silently.
                if (mon_cnt_r == SAMPLES) begin
                    mon_mosi_r  <= mon_mosi_sh_r;
                    mon_miso_r  <= mon_miso_sh_r;
                    mon_valid_r <= 1'b1;
                end
                mon_cnt_r <= '0;
            end else if (mon_sample_s) begin
                mon_mosi_sh_r <= shift_in(mon_mosi_sh_r, mosi_q_r);
                mon_miso_sh_r <= shift_in(mon_miso_sh_r, miso_q_r);
                if (mon_cnt_r != {SC_W{1'b1}}) begin
                    mon_cnt_r <= mon_cnt_r + SC_W'(1);
                end
            end
        end
    end

    assign mon_valid = mon_valid_r;
    assign mon_mosi  = mon_mosi_r;
    assign mon_miso  = mon_miso_r;

endmodule

// File: tb/tb_spi_master_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_master_engine
//
// Two engines share the host-side stimulus: instance 0 is MSB-first and
// instance 1 is LSB-first. Each instance has its own behavioural SPI slave.
// The slave reacts to sclk edges, shifts out a chosen word and records the
// mosi bits it sees in time order.
//
// Expected values come from the frame rules:
//   - rx_data and mon_miso equal the slave word.
//   - mon_mosi equals tx_data.
//   - The mosi bit sequence is tx_data in the instance's bit order.
//   - cs_n is low for (2*8+2)*max(div,1) cycles.
//   - There is exactly one done and one mon_valid per frame.
// -----------------------------------------------------------------------------
module tb_spi_master_engine;

    localparam int DW = 8;

    logic          pclk = 1'b0;
    logic          areset;
    logic          start;
    logic [DW-1:0] tx_data;
    logic          cpol, cpha;
    logic [7:0]    baud_div;

    logic          miso_s      [2];
    logic          busy_s      [2];
    logic          done_s      [2];
    logic          sclk_s      [2];
    logic          cs_n_s      [2];
    logic          mosi_s      [2];
    logic          mon_valid_s [2];
    logic [DW-1:0] rx_data_s   [2];
    logic [DW-1:0] mon_mosi_s  [2];
    logic [DW-1:0] mon_miso_s  [2];

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    spi_master_engine #(.DATA_WIDTH(DW), .DIV_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .pclk(pclk), .areset(areset), .start(start), .tx_data(tx_data),
        .cpol(cpol), .cpha(cpha), .baud_div(baud_div),
        .busy(busy_s[0]), .done(done_s[0]), .rx_data(rx_data_s[0]),
        .sclk(sclk_s[0]), .cs_n(cs_n_s[0]), .mosi(mosi_s[0]), .miso(miso_s[0]),
        .mon_valid(mon_valid_s[0]), .mon_mosi(mon_mosi_s[0]), .mon_miso(mon_miso_s[0])
    );

    spi_master_engine #(.DATA_WIDTH(DW), .DIV_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .pclk(pclk), .areset(areset), .start(start), .tx_data(tx_data),
        .cpol(cpol), .cpha(cpha), .baud_div(baud_div),
        .busy(busy_s[1]), .done(done_s[1]), .rx_data(rx_data_s[1]),
        .sclk(sclk_s[1]), .cs_n(cs_n_s[1]), .mosi(mosi_s[1]), .miso(miso_s[1]),
        .mon_valid(mon_valid_s[1]), .mon_mosi(mon_mosi_s[1]), .mon_miso(mon_miso_s[1])
    );

    // Single comparison point.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bit k in transmission order for instance inst (0 = MSB-first, 1 = LSB-first).
    function automatic logic bitsel(input logic [DW-1:0] w, input int inst, input int k);
        if (inst == 0) return w[DW-1-k];
        else           return w[k];
    endfunction

    function automatic logic [DW-1:0] rev(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int k = 0; k < DW; k++) r[k] = w[DW-1-k];
        return r;
    endfunction

    // ------------------------------------------------------- slave models
    logic [DW-1:0] slv_word  [2] = '{8'h00, 8'h00};
    logic [DW-1:0] seen_seq  [2] = '{8'h00, 8'h00};
    int            seen_cnt  [2] = '{0, 0};
    int            out_idx   [2] = '{0, 0};
    logic          slv_cpol  [2] = '{1'b0, 1'b0};
    logic          prev_sclk [2] = '{1'b0, 1'b0};
    logic          prev_csn  [2] = '{1'b1, 1'b1};

    initial begin
        miso_s[0] = 1'b0;
        miso_s[1] = 1'b0;
    end

    // The slave updates half a pclk cycle after the sclk change that it observes.
    always @(negedge pclk) begin
        for (int i = 0; i < 2; i++) begin
            if (prev_csn[i] && !cs_n_s[i]) begin
                slv_cpol[i] = sclk_s[i];
                seen_cnt[i] = 0;
                seen_seq[i] = '0;
                if (!cpha) begin
                    miso_s[i]  = bitsel(slv_word[i], i, 0);
                    out_idx[i] = 1;
                end else begin
                    out_idx[i] = 0;
                end
            end else if (!cs_n_s[i] && (sclk_s[i] != prev_sclk[i])) begin
                if ((sclk_s[i] != slv_cpol[i]) ^ cpha) begin
                    seen_seq[i] = {seen_seq[i][DW-2:0], mosi_s[i]};
                    seen_cnt[i]++;
                end else if (out_idx[i] < DW) begin
                    miso_s[i]  = bitsel(slv_word[i], i, out_idx[i]);
                    out_idx[i]++;
                end
            end
            prev_csn[i]  = cs_n_s[i];
            prev_sclk[i] = sclk_s[i];
        end
    end

    // Running event counters; the tasks below take before/after differences.
    int csn_low_cnt [2] = '{0, 0};
    int done_cnt    [2] = '{0, 0};
    int mv_cnt      [2] = '{0, 0};

    always @(posedge pclk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_n_s[i] === 1'b0)      csn_low_cnt[i]++;
            if (done_s[i] === 1'b1)      done_cnt[i]++;
            if (mon_valid_s[i] === 1'b1) mv_cnt[i]++;
        end
    end

    // --------------------------------------------------------- frame task
    task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] s0,
                             input logic [DW-1:0] s1, input logic pol, input logic pha,
                             input logic [7:0] div, input bit extra_start);
        int n;
        int budget;
        int c0 [2];
        int d0 [2];
        int m0 [2];
        n = (div == 8'd0) ? 1 : int'(div);
        slv_word[0] = s0;
        slv_word[1] = s1;
        cpol     = pol;
        cpha     = pha;
        baud_div = div;
        tx_data  = tx;
        repeat (2) @(negedge pclk);
        check("idle_sclk", {31'd0, sclk_s[0]}, {31'd0, pol});
        check("idle_cs_n", {31'd0, cs_n_s[1]}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            c0[i] = csn_low_cnt[i];
            d0[i] = done_cnt[i];
            m0[i] = mv_cnt[i];
        end
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        check("cs_fall_lat", {31'd0, cs_n_s[0]}, 32'd0);
        check("busy_set", {31'd0, busy_s[0]}, 32'd1);
        if (extra_start) begin
            repeat (3) @(negedge pclk);
            tx_data = ~tx;
            start   = 1'b1;
            @(negedge pclk);
            start = 1'b0;
        end
        budget = 0;
        while (done_s[0] !== 1'b1 && budget < 2000) begin
            @(negedge pclk);
            budget++;
        end
        check("done_seen", {31'd0, done_s[0]}, 32'd1);
        check("done_both", {31'd0, done_s[1]}, 32'd1);
        check("busy_clr", {31'd0, busy_s[0]}, 32'd0);
        check("rx_msb", {24'd0, rx_data_s[0]}, {24'd0, s0});
        check("rx_lsb", {24'd0, rx_data_s[1]}, {24'd0, s1});
        // A start coinciding with done must be ignored.
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        check("start_on_done_ign", {31'd0, cs_n_s[0]}, 32'd1);
        check("busy_after_done", {31'd0, busy_s[0]}, 32'd0);
        @(negedge pclk);
        check("mon_valid_lat", {31'd0, mon_valid_s[0]}, 32'd1);
        @(negedge pclk);
        for (int i = 0; i < 2; i++) begin
            check("cs_low_len", csn_low_cnt[i] - c0[i], (2 * DW + 2) * n);
            check("done_count", done_cnt[i] - d0[i], 32'd1);
            check("mv_count", mv_cnt[i] - m0[i], 32'd1);
            check("mon_mosi", {24'd0, mon_mosi_s[i]}, {24'd0, tx});
            check("mon_miso", {24'd0, mon_miso_s[i]}, {24'd0, (i == 0) ? s0 : s1});
            check("slv_bits", seen_cnt[i], DW);
            check("mosi_seq", {24'd0, seen_seq[i]}, {24'd0, (i == 0) ? tx : rev(tx)});
        end
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin
        int d0;
        int m0;
        areset   = 1'b1;
        start    = 1'b0;
        tx_data  = '0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        baud_div = 8'd2;
        repeat (3) @(negedge pclk);
        for (int i = 0; i < 2; i++) begin
            check("rst_cs_n", {31'd0, cs_n_s[i]}, 32'd1);
            check("rst_sclk", {31'd0, sclk_s[i]}, 32'd0);
            check("rst_mosi", {31'd0, mosi_s[i]}, 32'd0);
            check("rst_busy", {31'd0, busy_s[i]}, 32'd0);
            check("rst_done", {31'd0, done_s[i]}, 32'd0);
            check("rst_rx", {24'd0, rx_data_s[i]}, 32'd0);
            check("rst_mv", {31'd0, mon_valid_s[i]}, 32'd0);
            check("rst_mon", {16'd0, mon_mosi_s[i], mon_miso_s[i]}, 32'd0);
        end
        areset = 1'b0;

        // Directed frames.
        run_frame(8'hA5, 8'h3C, 8'h3C, 1'b0, 1'b0, 8'd2, 1'b0);
        run_frame(8'h0F, 8'hF0, 8'hF0, 1'b1, 1'b1, 8'd1, 1'b0);
        run_frame(8'h5A, 8'h96, 8'h69, 1'b0, 1'b1, 8'd0, 1'b0);
        run_frame(8'hC3, 8'h81, 8'h7E, 1'b1, 1'b0, 8'd3, 1'b1);

        // Reset in the middle of a mode-1 frame.
        cpol      = 1'b0;
        cpha      = 1'b1;
        baud_div  = 8'd2;
        tx_data   = 8'hE7;
        d0        = done_cnt[0];
        m0        = mv_cnt[0];
        @(negedge pclk);
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        repeat (10) @(negedge pclk);
        areset = 1'b1;
        @(negedge pclk);
        check("mid_rst_cs_n", {31'd0, cs_n_s[0]}, 32'd1);
        check("mid_rst_sclk", {31'd0, sclk_s[0]}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_s[0]}, 32'd0);
        check("mid_rst_rx", {24'd0, rx_data_s[0]}, 32'd0);
        check("mid_rst_mon", {24'd0, mon_mosi_s[0]}, 32'd0);
        areset = 1'b0;
        repeat (60) @(negedge pclk);
        check("mid_rst_no_done", done_cnt[0] - d0, 32'd0);
        check("mid_rst_no_mv", mv_cnt[0] - m0, 32'd0);
        run_frame(8'h81, 8'h5C, 8'hA3, 1'b0, 1'b1, 8'd2, 1'b0);

        // LSB-first instance: first mosi bit of 0x01 must be 1.
        run_frame(8'h01, 8'h12, 8'h34, 1'b0, 1'b0, 8'd1, 1'b0);
        check("lsb_first_bit", {31'd0, seen_seq[1][DW-1]}, 32'd1);

        // Randomised frames.
        for (int r = 0; r < 20; r++) begin
            run_frame(DW'($urandom), DW'($urandom), DW'($urandom),
                      1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      8'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
